// File: rtl/scr1_timer_mch.sv
// scr1_timer_mch: multi-channel memory-mapped machine timer.
//
// A 64-bit free-running mtime counter advanced by a programmable prescaler
// (clocked from clk or from the rtc_tick strobe), plus N_CH independent
// 64-bit compare channels. Each channel is one-shot or auto-reload and owns
// a sticky W1C pending bit and an interrupt enable.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   rtc_tick          - external time-base strobe (clk-synchronous, 1 cycle)
//   dmem_req/cmd/width/addr/wdata - dmem request; addr[7:0] decoded
//   dmem_req_ack      - always 1, every request is taken immediately
//   dmem_rdata/resp   - registered response, one cycle after the request
//   timer_val         - current mtime
//   timer_irq         - pending & irq_en, per channel
//   timer_irq_any     - OR of timer_irq

package scr1_memif_pkg;
    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_timer_mch
    import scr1_memif_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DIV_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rtc_tick,
    input  logic                        dmem_req,
    input  type_scr1_mem_cmd_e          dmem_cmd,
    input  type_scr1_mem_width_e        dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    output logic                        dmem_req_ack,
    output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    output type_scr1_mem_resp_e         dmem_resp,
    output logic [63:0]                 timer_val,
    output logic [N_CH-1:0]             timer_irq,
    output logic                        timer_irq_any
);

    // Global register word index (offset[4:2]); 6 and 7 are unmapped.
    localparam logic [2:0] REG_CONTROL = 3'd0;
    localparam logic [2:0] REG_DIVIDER = 3'd1;
    localparam logic [2:0] REG_MTIMELO = 3'd2;
    localparam logic [2:0] REG_MTIMEHI = 3'd3;
    localparam logic [2:0] REG_PENDING = 3'd4;
    localparam logic [2:0] REG_IRQ_EN  = 3'd5;

    // Channel register word index (offset[3:2]).
    localparam logic [1:0] CH_CMPLO  = 2'd0;
    localparam logic [1:0] CH_CMPHI  = 2'd1;
    localparam logic [1:0] CH_CTRL   = 2'd2;
    localparam logic [1:0] CH_RELOAD = 2'd3;

    localparam logic [3:0]  NCH4  = 4'(N_CH);
    localparam int unsigned NCH_U = N_CH;

    // Register state
    logic                 ctrl_en;
    logic                 ctrl_clksrc;
    logic [DIV_WIDTH-1:0] divider;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [63:0]          mtime;
    logic [N_CH-1:0]      pending;
    logic [N_CH-1:0]      irq_en;
    logic [N_CH-1:0]      ch_en;
    logic [N_CH-1:0]      ch_auto;
    logic [63:0]          cmp    [N_CH];
    logic [31:0]          reload [N_CH];

    // Next-state values
    logic [DIV_WIDTH-1:0] div_cnt_nx;
    logic [63:0]          mtime_nx;
    logic [N_CH-1:0]      pending_nx;
    logic [N_CH-1:0]      ch_en_nx;
    logic [N_CH-1:0]      ch_auto_nx;
    logic [63:0]          cmp_nx    [N_CH];
    logic [31:0]          reload_nx [N_CH];

    // Address decode
    logic [7:0]  off;
    logic        in_ch;
    logic [3:0]  ch_sel;
    logic        mapped;
    logic        acc_ok;
    logic        wr_en;
    logic        wr_glb;
    logic        wr_ch;
    logic        wr_control;
    logic        wr_divider;
    logic        wr_mtlo;
    logic        wr_mthi;
    logic        wr_pending;
    logic        wr_irq_en;
    logic [N_CH-1:0] wr_cmplo;
    logic [N_CH-1:0] wr_cmphi;
    logic [N_CH-1:0] wr_ctrl;
    logic [N_CH-1:0] wr_reload;
    logic [31:0] rd_val;

    logic            cnt_en;
    logic            tick;
    logic [N_CH-1:0] fire;

    logic unused_addr;
    assign unused_addr = ^dmem_addr[SCR1_DMEM_AWIDTH-1:8];

    assign off    = dmem_addr[7:0];
    assign in_ch  = (off[7:5] != 3'd0);
    // Channel blocks start at 0x20, so block index is offset[7:4] - 2.
    assign ch_sel = off[7:4] - 4'd2;
    assign mapped = in_ch ? (ch_sel < NCH4) : (off[4:2] < 3'd6);
    assign acc_ok = dmem_req && (dmem_width == SCR1_MEM_WIDTH_WORD)
                    && (off[1:0] == 2'b00) && mapped;
    assign wr_en  = acc_ok && (dmem_cmd == SCR1_MEM_CMD_WR);
    assign wr_glb = wr_en && !in_ch;
    assign wr_ch  = wr_en && in_ch;

    assign wr_control = wr_glb && (off[4:2] == REG_CONTROL);
    assign wr_divider = wr_glb && (off[4:2] == REG_DIVIDER);
    assign wr_mtlo    = wr_glb && (off[4:2] == REG_MTIMELO);
    assign wr_mthi    = wr_glb && (off[4:2] == REG_MTIMEHI);
    assign wr_pending = wr_glb && (off[4:2] == REG_PENDING);
    assign wr_irq_en  = wr_glb && (off[4:2] == REG_IRQ_EN);

    always_comb begin
        for (int unsigned i = 0; i < NCH_U; i++) begin
            wr_cmplo[i]  = wr_ch && (ch_sel == 4'(i)) && (off[3:2] == CH_CMPLO);
            wr_cmphi[i]  = wr_ch && (ch_sel == 4'(i)) && (off[3:2] == CH_CMPHI);
            wr_ctrl[i]   = wr_ch && (ch_sel == 4'(i)) && (off[3:2] == CH_CTRL);
            wr_reload[i] = wr_ch && (ch_sel == 4'(i)) && (off[3:2] == CH_RELOAD);
        end
    end

    // Prescaler and mtime
    assign cnt_en = ctrl_en && (ctrl_clksrc ? rtc_tick : 1'b1);
    assign tick   = cnt_en && (div_cnt == '0);

    always_comb begin
        div_cnt_nx = div_cnt;
        if (wr_divider) begin
            div_cnt_nx = dmem_wdata[DIV_WIDTH-1:0];
        end else if (tick) begin
            div_cnt_nx = divider;
        end else if (cnt_en) begin
            div_cnt_nx = div_cnt - 1'b1;
        end

        // A half-write lands on top of the incremented value.
        mtime_nx = mtime + {63'd0, tick};
        if (wr_mtlo) mtime_nx[31:0]  = dmem_wdata;
        if (wr_mthi) mtime_nx[63:32] = dmem_wdata;
    end

    // Compare channels
    always_comb begin
        for (int unsigned i = 0; i < NCH_U; i++) begin
            fire[i] = ch_en[i] && (mtime >= cmp[i]);

            cmp_nx[i] = (fire[i] && ch_auto[i]) ? cmp[i] + {32'd0, reload[i]} : cmp[i];
            if (wr_cmplo[i]) cmp_nx[i][31:0]  = dmem_wdata;
            if (wr_cmphi[i]) cmp_nx[i][63:32] = dmem_wdata;

            ch_en_nx[i]   = ch_en[i] && !(fire[i] && !ch_auto[i]);
            ch_auto_nx[i] = ch_auto[i];
            if (wr_ctrl[i]) begin
                ch_en_nx[i]   = dmem_wdata[0];
                ch_auto_nx[i] = dmem_wdata[1];
            end

            reload_nx[i] = wr_reload[i] ? dmem_wdata : reload[i];
        end
        // Set beats a simultaneous W1C.
        pending_nx = (pending & ~(wr_pending ? dmem_wdata[N_CH-1:0] : '0)) | fire;
    end

    // Read mux
    always_comb begin
        rd_val = '0;
        if (!in_ch) begin
            case (off[4:2])
                REG_CONTROL: rd_val = {30'd0, ctrl_clksrc, ctrl_en};
                REG_DIVIDER: rd_val = 32'(divider);
                REG_MTIMELO: rd_val = mtime[31:0];
                REG_MTIMEHI: rd_val = mtime[63:32];
                REG_PENDING: rd_val = 32'(pending);
                REG_IRQ_EN:  rd_val = 32'(irq_en);
                default:     rd_val = '0;
            endcase
        end else begin
            for (int unsigned i = 0; i < NCH_U; i++) begin
                if (ch_sel == 4'(i)) begin
                    case (off[3:2])
                        CH_CMPLO:  rd_val = cmp[i][31:0];
                        CH_CMPHI:  rd_val = cmp[i][63:32];
                        CH_CTRL:   rd_val = {30'd0, ch_auto[i], ch_en[i]};
                        CH_RELOAD: rd_val = reload[i];
                        default:   rd_val = '0;
                    endcase
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en     <= 1'b1;
            ctrl_clksrc <= 1'b0;
            divider     <= '0;
            div_cnt     <= '0;
            mtime       <= '0;
            pending     <= '0;
            irq_en      <= '0;
            ch_en       <= '0;
            ch_auto     <= '0;
            for (int unsigned i = 0; i < NCH_U; i++) begin
                cmp[i]    <= '0;
                reload[i] <= '0;
            end
        end else begin
            if (wr_control) begin
                ctrl_en     <= dmem_wdata[0];
                ctrl_clksrc <= dmem_wdata[1];
            end
            if (wr_divider) divider <= dmem_wdata[DIV_WIDTH-1:0];
            if (wr_irq_en)  irq_en  <= dmem_wdata[N_CH-1:0];
            div_cnt <= div_cnt_nx;
            mtime   <= mtime_nx;
            pending <= pending_nx;
            ch_en   <= ch_en_nx;
            ch_auto <= ch_auto_nx;
            for (int unsigned i = 0; i < NCH_U; i++) begin
                cmp[i]    <= cmp_nx[i];
                reload[i] <= reload_nx[i];
            end
        end
    end

    // Response: read data only moves on valid reads; an error keeps it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
            dmem_rdata <= '0;
        end else if (!dmem_req) begin
            dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
            dmem_rdata <= '0;
        end else if (acc_ok) begin
            dmem_resp <= SCR1_MEM_RESP_RDY_OK;
            if (dmem_cmd == SCR1_MEM_CMD_RD) dmem_rdata <= rd_val;
        end else begin
            dmem_resp <= SCR1_MEM_RESP_RDY_ER;
        end
    end

    assign dmem_req_ack  = 1'b1;
    assign timer_val     = mtime;
    assign timer_irq     = pending & irq_en;
    assign timer_irq_any = |timer_irq;

endmodule

// File: tb/tb_scr1_timer_mch.sv
// Bench for scr1_timer_mch (N_CH=4, DIV_WIDTH=10). Bus expectations are
// queued when a request is driven and compared when its response appears.
module tb_scr1_timer_mch;
    import scr1_memif_pkg::*;

    localparam int N_CH      = 4;
    localparam int DIV_WIDTH = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rtc_tick = 1'b0;
    logic                 dmem_req = 1'b0;
    type_scr1_mem_cmd_e   dmem_cmd = SCR1_MEM_CMD_RD;
    type_scr1_mem_width_e dmem_width = SCR1_MEM_WIDTH_WORD;
    logic [31:0]          dmem_addr = '0;
    logic [31:0]          dmem_wdata = '0;
    logic                 dmem_req_ack;
    logic [31:0]          dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;
    logic [63:0]          timer_val;
    logic [N_CH-1:0]      timer_irq;
    logic                 timer_irq_any;

    scr1_timer_mch #(.N_CH(N_CH), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rtc_tick     (rtc_tick),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_req_ack (dmem_req_ack),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .timer_val    (timer_val),
        .timer_irq    (timer_irq),
        .timer_irq_any(timer_irq_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        string               tag;
        type_scr1_mem_resp_e resp;
        logic [31:0]         data;
        bit                  chk_data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic        mon_req;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          n_mt;
    int          n_irq;
    logic [63:0] fires[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response monitor: a request seen at an edge yields its response there.
    always @(posedge clk) begin
        mon_req = dmem_req && !rst;
        #1;
        if (mon_req) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.tag, "_resp"}, 64'(dmem_resp), 64'(mon_e.resp));
                if (mon_e.chk_data) check({mon_e.tag, "_data"}, 64'(dmem_rdata), 64'(mon_e.data));
            end
        end
    end

    // Called at a negedge; occupies exactly one cycle, returns at the next negedge.
    task automatic bus(input string tag, input bit wr, input logic [7:0] addr,
                       input logic [31:0] wd, input type_scr1_mem_width_e w,
                       input type_scr1_mem_resp_e exp_resp, input logic [31:0] exp_data,
                       input bit chk_data);
        exp_t e;
        dmem_req   = 1'b1;
        dmem_cmd   = wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        dmem_width = w;
        dmem_addr  = {24'h0, addr};
        dmem_wdata = wd;
        e.tag = tag; e.resp = exp_resp; e.data = exp_data; e.chk_data = chk_data;
        sb_q.push_back(e);
        @(negedge clk);
        dmem_req = 1'b0;
    endtask

    task automatic wr32(input logic [7:0] addr, input logic [31:0] wd);
        bus($sformatf("wr_%02h", addr), 1'b1, addr, wd, SCR1_MEM_WIDTH_WORD,
            SCR1_MEM_RESP_RDY_OK, 32'h0, 1'b0);
    endtask

    task automatic rd32(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        bus(tag, 1'b0, addr, 32'h0, SCR1_MEM_WIDTH_WORD, SCR1_MEM_RESP_RDY_OK, exp, 1'b1);
    endtask

    task automatic bad(input string tag, input bit wr, input logic [7:0] addr,
                       input type_scr1_mem_width_e w, input logic [31:0] keep_data);
        bus(tag, wr, addr, 32'h1234, w, SCR1_MEM_RESP_RDY_ER, keep_data, 1'b1);
    endtask

    task automatic rtc_pulse();
        rtc_tick = 1'b1;
        @(negedge clk);
        rtc_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_timer_val", timer_val, 64'd0);
        check("rst_irq", 64'(timer_irq), 64'd0);
        check("rst_irq_any", 64'(timer_irq_any), 64'd0);
        check("rst_resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
        check("rst_rdata", 64'(dmem_rdata), 64'd0);
        check("req_ack", 64'(dmem_req_ack), 64'd1);
        rst = 1'b0;
        rd32("rst_mtlo", 8'h08, 32'h0);
        rd32("rst_control", 8'h00, 32'h1);
        rd32("rst_ch2_ctrl", 8'h48, 32'h0);
        bad("unmapped_60", 1'b0, 8'h60, SCR1_MEM_WIDTH_WORD, 32'h0);
        bad("unmapped_18", 1'b0, 8'h18, SCR1_MEM_WIDTH_WORD, 32'h0);

        // One-shot channel 0 with DIVIDER=3
        wr32(8'h00, 32'h0);
        wr32(8'h08, 32'h0);
        wr32(8'h0C, 32'h0);
        wr32(8'h04, 32'h3);
        wr32(8'h20, 32'd5);
        wr32(8'h24, 32'h0);
        wr32(8'h14, 32'h1);
        wr32(8'h28, 32'h1);
        wr32(8'h00, 32'h1);
        n_mt = -1;
        n_irq = -1;
        for (int n = 0; n < 100; n++) begin
            if (n_mt < 0 && timer_val == 64'd5) n_mt = n;
            if (n_irq < 0 && timer_irq[0]) n_irq = n;
            if (n_irq >= 0) break;
            @(negedge clk);
        end
        check("div3_mtime5_cycle", 64'(n_mt), 64'd20);
        check("div3_irq_cycle", 64'(n_irq), 64'd21);
        check("div3_irq_any", 64'(timer_irq_any), 64'd1);
        rd32("oneshot_ctrl", 8'h28, 32'h0);
        rd32("oneshot_pending", 8'h10, 32'h1);
        wr32(8'h10, 32'h1);
        check("w1c_irq", 64'(timer_irq), 64'd0);
        check("w1c_irq_any", 64'(timer_irq_any), 64'd0);

        // Auto-reload channel 1, DIVIDER=0
        wr32(8'h00, 32'h0);
        wr32(8'h10, 32'hF);
        wr32(8'h08, 32'h0);
        wr32(8'h04, 32'h0);
        wr32(8'h30, 32'd10);
        wr32(8'h34, 32'h0);
        wr32(8'h3C, 32'd10);
        wr32(8'h38, 32'h3);
        wr32(8'h14, 32'h2);
        wr32(8'h00, 32'h1);
        for (int n = 0; n < 200; n++) begin
            if (timer_irq[1]) begin
                fires.push_back(timer_val - 64'd1);
                if (fires.size() == 3) break;
                wr32(8'h10, 32'h2);
            end else begin
                @(negedge clk);
            end
        end
        check("auto_fire_count", 64'(fires.size()), 64'd3);
        if (fires.size() == 3) begin
            check("auto_fire0", fires[0], 64'd10);
            check("auto_fire1", fires[1], 64'd20);
            check("auto_fire2", fires[2], 64'd30);
        end
        wr32(8'h00, 32'h0);
        wr32(8'h10, 32'h2);
        rd32("auto_mtime", 8'h08, 32'd32);
        rd32("auto_cmplo", 8'h30, 32'd40);
        rd32("auto_cmphi", 8'h34, 32'd0);
        rd32("auto_ctrl", 8'h38, 32'h3);
        wr32(8'h38, 32'h0);

        // 64-bit wrap, channel 2 at all-ones
        wr32(8'h0C, 32'hFFFF_FFFF);
        wr32(8'h08, 32'hFFFF_FFFE);
        wr32(8'h40, 32'hFFFF_FFFF);
        wr32(8'h44, 32'hFFFF_FFFF);
        wr32(8'h48, 32'h1);
        wr32(8'h14, 32'h4);
        wr32(8'h00, 32'h1);
        check("wrap_t0", timer_val, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        check("wrap_t1", timer_val, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_t1_irq", 64'(timer_irq), 64'd0);
        @(negedge clk);
        check("wrap_t2", timer_val, 64'd0);
        check("wrap_t2_irq", 64'(timer_irq), 64'h4);
        rd32("wrap_mtlo", 8'h08, 32'h0);
        rd32("wrap_mthi", 8'h0C, 32'h0);
        wr32(8'h10, 32'h4);
        repeat (4) @(negedge clk);
        check("wrap_once_irq", 64'(timer_irq), 64'd0);
        rd32("wrap_ch2_ctrl", 8'h48, 32'h0);

        // rtc_tick time base
        wr32(8'h00, 32'h0);
        wr32(8'h08, 32'h0);
        wr32(8'h0C, 32'h0);
        wr32(8'h04, 32'h0);
        wr32(8'h00, 32'h3);
        repeat (4) @(negedge clk);
        check("rtc_idle", timer_val, 64'd0);
        repeat (3) rtc_pulse();
        check("rtc_three", timer_val, 64'd3);
        wr32(8'h00, 32'h2);
        repeat (2) rtc_pulse();
        check("rtc_disabled", timer_val, 64'd3);
        rd32("rtc_control", 8'h00, 32'h2);
        rd32("rtc_mtlo", 8'h08, 32'd3);

        // W1C in the fire cycle: set wins
        wr32(8'h00, 32'h0);
        wr32(8'h08, 32'h0);
        wr32(8'h20, 32'h0);
        wr32(8'h24, 32'h0);
        wr32(8'h10, 32'hF);
        wr32(8'h28, 32'h1);
        wr32(8'h10, 32'h1);
        rd32("w1c_vs_set", 8'h10, 32'h1);

        // CTRL write in the fire cycle overrides one-shot clear
        wr32(8'h58, 32'h1);
        wr32(8'h58, 32'h1);
        rd32("ctrl_override", 8'h58, 32'h1);
        wr32(8'h58, 32'h0);
        rd32("pending_ch0_ch3", 8'h10, 32'h9);
        wr32(8'h14, 32'h0);
        check("irq_masked", 64'(timer_irq), 64'd0);
        check("irq_any_masked", 64'(timer_irq_any), 64'd0);
        wr32(8'h14, 32'h8);
        check("irq_ch3", 64'(timer_irq), 64'h8);
        check("irq_any_ch3", 64'(timer_irq_any), 64'd1);

        // Invalid accesses
        bad("hword_mtlo", 1'b1, 8'h08, SCR1_MEM_WIDTH_HWORD, 32'h9);
        rd32("hword_no_effect", 8'h08, 32'h0);
        bad("byte_control", 1'b0, 8'h00, SCR1_MEM_WIDTH_BYTE, 32'h0);
        bad("misaligned", 1'b1, 8'h02, SCR1_MEM_WIDTH_WORD, 32'h0);
        bad("unmapped_1c", 1'b1, 8'h1C, SCR1_MEM_WIDTH_WORD, 32'h0);
        rd32("after_bad_control", 8'h00, 32'h0);

        // Reset during an access
        rst        = 1'b1;
        dmem_req   = 1'b1;
        dmem_cmd   = SCR1_MEM_CMD_WR;
        dmem_width = SCR1_MEM_WIDTH_WORD;
        dmem_addr  = 32'h14;
        dmem_wdata = 32'hF;
        @(negedge clk);
        dmem_req = 1'b0;
        check("rst_mid_resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
        check("rst_mid_rdata", 64'(dmem_rdata), 64'd0);
        check("rst_mid_irq", 64'(timer_irq), 64'd0);
        check("rst_mid_mtime", timer_val, 64'd0);
        rst = 1'b0;
        rd32("rst_mid_irq_en", 8'h14, 32'h0);
        rd32("rst_mid_control", 8'h00, 32'h1);

        @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/scr1_timer_mch.md
# scr1_timer_mch

Multi-channel memory-mapped machine timer: a 64-bit free-running `mtime` counter with a programmable prescaler and `N_CH` independent 64-bit compare channels. Each channel runs in one-shot or auto-reload (periodic) mode and has a sticky write-1-to-clear pending bit and a per-channel interrupt enable. It sits on the core's dmem port in place of the single-compare timer. It drives `timer_val` to the core CSR file and per-channel plus aggregate IRQs to the interrupt controller.

## Interface
- `N_CH`, 4: number of compare channels, legal range 1..8.
- `DIV_WIDTH`, 10: prescaler width in bits, legal range 1..32.
- `clk` in 1: the only clock; all state is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rtc_tick` in 1: external time-base strobe, already synchronous to `clk`, one cycle wide.
- `dmem_req` in 1: access request.
- `dmem_cmd` in `type_scr1_mem_cmd_e`: RD/WR.
- `dmem_width` in `type_scr1_mem_width_e`: access width.
- `dmem_addr` in `SCR1_DMEM_AWIDTH`: byte address; only bits [7:0] are decoded.
- `dmem_wdata` in `SCR1_DMEM_DWIDTH`: write data.
- `dmem_req_ack` out 1: constant 1.
- `dmem_rdata` out `SCR1_DMEM_DWIDTH`: registered read data.
- `dmem_resp` out `type_scr1_mem_resp_e`: registered response.
- `timer_val` out 64: current `mtime`.
- `timer_irq` out `N_CH`: `pending & irq_en`.
- `timer_irq_any` out 1: OR-reduction of `timer_irq`.

## Operation
- Global register map:
  - 0x00 CONTROL: [0] EN, reset 1; [1] CLKSRC, reset 0 (0 = `clk`, 1 = `rtc_tick`).
  - 0x04 DIVIDER: [`DIV_WIDTH`-1:0], reset 0.
  - 0x08 MTIMELO and 0x0C MTIMEHI: reset 0.
  - 0x10 PENDING: [`N_CH`-1:0], W1C, reset 0.
  - 0x14 IRQ_EN: [`N_CH`-1:0], reset 0.
- Channel i register block at base 0x20+0x10·i, i < `N_CH`:
  - +0x0 CMPLO, +0x4 CMPHI: reset 0.
  - +0x8 CTRL: [0] CH_EN, [1] AUTO; reset 0.
  - +0xC RELOAD: 32-bit, reset 0.
- Unused register bits read 0 and ignore writes.
- Prescaler:
  - `cnt_en = CONTROL.EN & (CLKSRC ? rtc_tick : 1)`.
  - `tick = cnt_en & (div_cnt == 0)`.
  - On `tick`: `div_cnt <= DIVIDER`. Otherwise, when `cnt_en`: `div_cnt` decrements.
  - A DIVIDER write loads `div_cnt` with the written value; this has priority over the `tick` reload.
  - Net effect: DIVIDER = D gives one `mtime` increment per D+1 enabled cycles.
- `mtime`:
  - On `tick`: `+1`, wrapping modulo 2^64.
  - An MTIMELO or MTIMEHI write replaces that half of the already-incremented value in the same cycle.
- Channel fire: `fire[i] = CH_EN[i] & (mtime >= cmp[i])`, unsigned 64-bit compare on current register values. On the next edge after `fire[i]`:
  - `pending[i] <= 1`.
  - If AUTO=0: hardware clears CH_EN[i] (one-shot).
  - If AUTO=1: `cmp[i] <= cmp[i] + zero_extend(RELOAD[i])`, modulo 2^64. With RELOAD=0 the channel fires every cycle.
- Priorities:
  - A software write to CMPLO, CMPHI or CTRL of channel i in the same cycle as `fire[i]` overrides the hardware update of that register.
  - `pending[i]` is still set in that cycle.
  - PENDING W1C in the same cycle as a set: the set wins.
- Access validity: a request is valid when it is word width, `addr[1:0]==0`, and bits [7:0] hit a mapped register.
  - Unmapped offsets: 0x18, 0x1C, and channel blocks with i ≥ `N_CH`.
  - An invalid request has no side effects.

## Timing
- Every valid request completes in one cycle.
- Response on the edge after `dmem_req`:
  - Valid request: `RDY_OK`; reads return the register value sampled in the request cycle.
  - Invalid request: `RDY_ER`, rdata unchanged.
  - No request: `NOTRDY`, rdata 0.
- Writes take effect at the request-cycle edge. A read of the same address in the next cycle returns the written value, after any hardware update at that same edge.
- `timer_irq` changes on the cycle after the fire cycle, or after the cycle of an IRQ_EN or PENDING write.
- Reset values:
  - `dmem_resp` = NOTRDY; `dmem_rdata` = 0.
  - `timer_val` = 0; `timer_irq` = 0; `timer_irq_any` = 0.
  - All registers at the reset values listed above.
- `rst` asserted mid-access: no response is issued and no register update takes effect.

## Test plan
- Reset, then read 0x00 → 0x1; read 0x08 → 0x0; read 0x48 with `N_CH`=4 (channel 2 CTRL) → 0x0, RDY_OK; read 0x60 with `N_CH`=4 → RDY_ER.
- DIVIDER=3, CH0 CMPLO=5, CTRL=0x1, IRQ_EN=1 → `timer_irq[0]` rises exactly 1 cycle after `mtime` reaches 5 (about 20 cycles); CH0 CTRL then reads 0x0; PENDING W1C of 0x1 drops the IRQ.
- CH1 AUTO: CMPLO=10, RELOAD=10, CTRL=0x3, DIVIDER=0 → `pending[1]` sets at `mtime` 10, 20, 30; CMPLO reads 40 after the third fire.
- Wrap: MTIMEHI=0xFFFFFFFF, MTIMELO=0xFFFFFFFE → `mtime` reads 0 two ticks later; a channel with cmp=0xFFFFFFFF_FFFFFFFF fires once.
- CLKSRC=1, DIVIDER=0, pulse `rtc_tick` 3 times → `mtime` +3 exactly; no increment while `rtc_tick`=0 or CONTROL.EN=0.
- Simultaneous events:
  - W1C of PENDING[0] in the fire cycle of CH0 → pending stays 1.
  - Halfword access to 0x08 → RDY_ER and `mtime` is not altered.
